// File: rtl/nibble_scan_sequencer_if.sv
// Scan request inputs and nibble-select outputs between the scan requester and the sequencer.
// The master side belongs to the sequencer. The slave side belongs to the requester and the input_selector consumer.
interface nibble_scan_sequencer_if #(
   parameter int MAIN_IDX_W = 4,
   parameter int REGS_IDX_W = 6,
   parameter int LEN_W      = 6
);
   logic                  start;
   logic                  origin_in;
   logic [REGS_IDX_W-1:0] base_idx;
   logic [LEN_W-1:0]      len_m1;
   logic                  stall;
   logic                  abort;

   logic                  wBusy;
   logic                  wSelecOrigin;
   logic [MAIN_IDX_W-1:0] wSelecMain;
   logic [REGS_IDX_W-1:0] wSelecRegs;
   logic                  valid;
   logic                  done;
   logic                  aborted;

   modport master (
      input  start, origin_in, base_idx, len_m1, stall, abort,
      output wBusy, wSelecOrigin, wSelecMain, wSelecRegs, valid, done, aborted
   );

   modport slave (
      output start, origin_in, base_idx, len_m1, stall, abort,
      input  wBusy, wSelecOrigin, wSelecMain, wSelecRegs, valid, done, aborted
   );
endinterface

// File: rtl/nibble_scan_sequencer.sv
// Walks a run of nibble indices over the main word or the register bank. The first index appears one cycle after start.
// Stall holds the index and clears valid. Abort ends the scan at the next edge.
module nibble_scan_sequencer #(
   parameter int MAIN_IDX_W = 4,
   parameter int REGS_IDX_W = 6
) (
   input  logic                     clk,
   input  logic                     reset,
   nibble_scan_sequencer_if.master  bus
);
   localparam int LEN_W = 6;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                r_state;
   logic                  r_origin;
   logic [MAIN_IDX_W-1:0] r_main;
   logic [REGS_IDX_W-1:0] r_regs;
   logic [LEN_W-1:0]      r_rem;
   logic                  r_aborted;

   state_t                w_state_nxt;
   logic                  w_origin_nxt;
   logic [MAIN_IDX_W-1:0] w_main_nxt;
   logic [REGS_IDX_W-1:0] w_regs_nxt;
   logic [LEN_W-1:0]      w_rem_nxt;
   logic                  w_aborted_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_origin  <= 1'b0;
         r_main    <= '0;
         r_regs    <= '0;
         r_rem     <= '0;
         r_aborted <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_origin  <= w_origin_nxt;
         r_main    <= w_main_nxt;
         r_regs    <= w_regs_nxt;
         r_rem     <= w_rem_nxt;
         r_aborted <= w_aborted_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_origin_nxt  = r_origin;
      w_main_nxt    = r_main;
      w_regs_nxt    = r_regs;
      w_rem_nxt     = r_rem;
      w_aborted_nxt = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_origin_nxt = bus.origin_in;
               w_main_nxt   = bus.origin_in ? '0 : bus.base_idx[MAIN_IDX_W-1:0];
               w_regs_nxt   = bus.origin_in ? bus.base_idx : '0;
               w_rem_nxt    = bus.len_m1;
               w_state_nxt  = S_RUN;
            end
         end
         S_RUN: begin
            // Abort wins over both stall and the final count.
            if (bus.abort) begin
               w_aborted_nxt = 1'b1;
               w_state_nxt   = S_IDLE;
            end else if (!bus.stall) begin
               if (r_rem == '0) begin
                  w_state_nxt = S_DONE;
               end else begin
                  if (r_origin) w_regs_nxt = r_regs + 1'b1;
                  else          w_main_nxt = r_main + 1'b1;
                  w_rem_nxt = r_rem - 1'b1;
               end
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign bus.wBusy        = (r_state == S_RUN);
   assign bus.valid        = (r_state == S_RUN) && !bus.stall;
   assign bus.done         = (r_state == S_DONE);
   assign bus.aborted      = r_aborted;
   assign bus.wSelecOrigin = r_origin;
   assign bus.wSelecMain   = r_main;
   assign bus.wSelecRegs   = r_regs;
endmodule

// File: tb/tb_nibble_scan_sequencer.sv
// Bench for nibble_scan_sequencer. A vector table holds per-cycle inputs and expected outputs.
// Hand-written sequences cover the full-bank scan and a start held high through a scan.
module tb_nibble_scan_sequencer;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   nibble_scan_sequencer_if #(.MAIN_IDX_W(4), .REGS_IDX_W(6), .LEN_W(6)) bus ();

   nibble_scan_sequencer #(.MAIN_IDX_W(4), .REGS_IDX_W(6)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic        rst;
      logic        st;
      logic        org;
      logic [5:0]  base;
      logic [5:0]  len;
      logic        stall;
      logic        abort;
      logic [14:0] exp;
   } vec_t;

   vec_t tbl[$];
   int checks = 0;
   int failures = 0;

   // Packed as {busy, origin, main[3:0], regs[5:0], valid, done, aborted}.
   function automatic logic [14:0] mk(int b, int o, int m, int r, int v, int d, int a);
      logic [3:0] mm;
      logic [5:0] rr;
      mm = m[3:0];
      rr = r[5:0];
      return {b[0], o[0], mm, rr, v[0], d[0], a[0]};
   endfunction

   function automatic logic [14:0] outs();
      return {bus.wBusy, bus.wSelecOrigin, bus.wSelecMain, bus.wSelecRegs,
              bus.valid, bus.done, bus.aborted};
   endfunction

   task automatic add(int rst, int st, int org, int base, int len, int stall, int abort,
                      logic [14:0] exp);
      vec_t v;
      v.rst = rst[0]; v.st = st[0]; v.org = org[0];
      v.base = base[5:0]; v.len = len[5:0];
      v.stall = stall[0]; v.abort = abort[0]; v.exp = exp;
      tbl.push_back(v);
   endtask

   task automatic drive(logic rst, logic st, logic org, logic [5:0] base, logic [5:0] len,
                        logic stall, logic abort);
      reset         = rst;
      bus.start     = st;
      bus.origin_in = org;
      bus.base_idx  = base;
      bus.len_m1    = len;
      bus.stall     = stall;
      bus.abort     = abort;
   endtask

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   logic       k_busy [8];
   logic [3:0] k_main [8];
   logic       k_done [8];

   initial begin
      drive(1'b1, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0);

      add(1,0,0, 0, 0,0,0, mk(0,0, 0, 0,0,0,0));
      add(0,1,0,14, 3,0,0, mk(0,0, 0, 0,0,0,0));
      add(0,0,0, 0, 0,0,0, mk(1,0,14, 0,1,0,0));
      add(0,0,0, 0, 0,0,0, mk(1,0,15, 0,1,0,0));
      add(0,0,0, 0, 0,0,0, mk(1,0, 0, 0,1,0,0));
      add(0,0,0, 0, 0,0,0, mk(1,0, 1, 0,1,0,0));
      add(0,0,0, 0, 0,0,0, mk(0,0, 1, 0,0,1,0));
      add(0,0,0, 0, 0,0,0, mk(0,0, 1, 0,0,0,0));
      add(0,1,1,62, 2,0,0, mk(0,0, 1, 0,0,0,0));
      add(0,0,0, 0, 0,0,0, mk(1,1, 0,62,1,0,0));
      add(0,0,0, 0, 0,1,0, mk(1,1, 0,63,0,0,0));
      add(0,0,0, 0, 0,1,0, mk(1,1, 0,63,0,0,0));
      add(0,0,0, 0, 0,0,0, mk(1,1, 0,63,1,0,0));
      add(0,0,0, 0, 0,0,0, mk(1,1, 0, 0,1,0,0));
      add(0,0,0, 0, 0,0,0, mk(0,1, 0, 0,0,1,0));
      add(0,0,0, 0, 0,0,0, mk(0,1, 0, 0,0,0,0));
      add(0,1,0, 0,10,0,0, mk(0,1, 0, 0,0,0,0));
      add(0,0,0, 0, 0,0,0, mk(1,0, 0, 0,1,0,0));
      add(0,0,0, 0, 0,0,0, mk(1,0, 1, 0,1,0,0));
      add(0,0,0, 0, 0,0,1, mk(1,0, 2, 0,1,0,0));
      add(0,0,0, 0, 0,0,0, mk(0,0, 2, 0,0,0,1));
      add(0,0,0, 0, 0,0,1, mk(0,0, 2, 0,0,0,0));
      add(0,1,1,18,10,0,0, mk(0,0, 2, 0,0,0,0));
      add(0,0,0, 0, 0,0,0, mk(1,1, 0,18,1,0,0));
      add(0,0,0, 0, 0,0,0, mk(1,1, 0,19,1,0,0));
      add(1,0,0, 0, 0,0,0, mk(1,1, 0,20,1,0,0));
      add(0,0,0, 0, 0,0,0, mk(0,0, 0, 0,0,0,0));
      add(0,1,0, 3, 0,0,0, mk(0,0, 0, 0,0,0,0));
      add(0,0,0, 0, 0,1,1, mk(1,0, 3, 0,0,0,0));
      add(0,0,0, 0, 0,0,0, mk(0,0, 3, 0,0,0,1));
      add(0,1,1,63, 0,0,0, mk(0,0, 3, 0,0,0,0));
      add(0,0,0, 0, 0,0,0, mk(1,1, 0,63,1,0,0));
      add(0,1,0, 9, 5,0,1, mk(0,1, 0,63,0,1,0));
      add(0,0,0, 0, 0,0,0, mk(0,1, 0,63,0,0,0));
      add(0,0,0, 0, 0,0,0, mk(0,1, 0,63,0,0,0));

      foreach (tbl[i]) begin
         @(negedge clk);
         drive(tbl[i].rst, tbl[i].st, tbl[i].org, tbl[i].base, tbl[i].len,
               tbl[i].stall, tbl[i].abort);
         #1;
         check($sformatf("row%0d", i), {17'd0, outs()}, {17'd0, tbl[i].exp});
      end

      // Full register-bank scan from 5: expect 5..63 then 0..4.
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b1, 6'd5, 6'd63, 1'b0, 1'b0);
      #1;
      check("full_idle_busy", {31'd0, bus.wBusy}, 32'd0);
      for (int i = 0; i < 64; i++) begin
         logic [5:0] e_idx;
         @(negedge clk);
         drive(1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0);
         #1;
         e_idx = 6'(5 + i);
         check($sformatf("full_step%0d", i),
               {23'd0, bus.wBusy, bus.valid, bus.done, e_idx == e_idx ? bus.wSelecRegs : 6'd0},
               {23'd0, 1'b1, 1'b1, 1'b0, e_idx});
      end
      @(negedge clk);
      #1;
      check("full_done", {28'd0, bus.wBusy, bus.valid, bus.done, bus.aborted}, 32'b0010);
      check("full_final_idx", {26'd0, bus.wSelecRegs}, 32'd4);

      // start held high: re-sampled only after DONE returns to IDLE.
      k_busy = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      k_main = '{4'd0, 4'd7, 4'd8, 4'd8, 4'd8, 4'd7, 4'd8, 4'd8};
      k_done = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         drive(1'b0, 1'b1, 1'b0, 6'd7, 6'd1, 1'b0, 1'b0);
         #1;
         check($sformatf("held_busy%0d", k), {31'd0, bus.wBusy}, {31'd0, k_busy[k]});
         check($sformatf("held_done%0d", k), {31'd0, bus.done}, {31'd0, k_done[k]});
         if (k > 0)
            check($sformatf("held_main%0d", k), {28'd0, bus.wSelecMain}, {28'd0, k_main[k]});
      end
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0);
      #1;
      check("held_end_idle", {30'd0, bus.wBusy, bus.done}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
